// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit result path: function select codes and their type.
package lu_pkg;

  typedef logic [1:0] lu_sel_t;

  localparam lu_sel_t SEL_OR   = 2'd0;
  localparam lu_sel_t SEL_NOR  = 2'd1;
  localparam lu_sel_t SEL_XOR  = 2'd2;
  localparam lu_sel_t SEL_XNOR = 2'd3;

  localparam int NUM_CHAN = 4;

endpackage

// File: rtl/lu_chan_shifter.sv
// One W-bit collector: bits land LSB-first; full is registered and blocks further writes.
// A completed word holds until clr; writes while full are ignored (the top never issues them).
module lu_chan_shifter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic         bit_in,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] word
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (wr_en && !full) begin
      for (int i = 0; i < W; i++) begin
        if (cnt == CW'(i)) begin
          word[i] <= bit_in;
        end
      end
      // The count parks at W so a full channel reads as exactly W collected bits.
      if (cnt == CW'(W - 1)) begin
        cnt  <= CW'(W);
        full <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lu_result_demux.sv
// Demuxes (select, bit) pairs into four shift registers; full words leave round-robin on one valid/ready port.
// 1 cycle from last-bit accept to out_valid; a full channel deasserts in_ready until its word is loaded.
module lu_result_demux
  import lu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  lu_sel_t      in_sel,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output lu_sel_t      out_chan,
  output logic [W-1:0] out_word
);

  logic [NUM_CHAN-1:0] full;
  logic [W-1:0]        words [NUM_CHAN];
  lu_sel_t             last_grant;
  lu_sel_t             grant;
  lu_sel_t             cand;
  logic                found;
  logic                accept;
  logic                out_free;
  logic                load;

  assign in_ready = !full[in_sel];
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign load     = out_free && found;

  // Search starts one past the last winner so no channel can starve another.
  always_comb begin
    found = 1'b0;
    grant = last_grant;
    cand  = '0;
    for (int i = 1; i <= NUM_CHAN; i++) begin
      cand = last_grant + 2'(i);
      if (!found && full[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
    lu_chan_shifter #(
      .W (W)
    ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (accept && (in_sel == 2'(k))),
      .bit_in (in_bit),
      .clr    (load && (grant == 2'(k))),
      .full   (full[k]),
      .word   (words[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_chan   <= SEL_OR;
      out_word   <= '0;
      last_grant <= SEL_XNOR;
    end else if (out_free) begin
      if (found) begin
        out_valid  <= 1'b1;
        out_chan   <= grant;
        out_word   <= words[grant];
        last_grant <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lu_result_demux.sv
// Directed bench for lu_result_demux (W=4): reset, single word, backpressure, round-robin, mid-word reset, interleave.
module tb_lu_result_demux;
  import lu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  lu_sel_t      in_sel;
  logic         in_bit;
  logic         out_valid;
  logic         out_ready;
  lu_sel_t      out_chan;
  logic [W-1:0] out_word;

  int vectors = 0;
  int miscompares = 0;

  lu_result_demux #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_word  (out_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one bit, waits (bounded) for in_ready, then lets it be taken on the next edge.
  task automatic send(input lu_sel_t s, input logic b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sel   = s;
    in_bit   = b;
    #1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", {15'd0, in_ready}, 16'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input lu_sel_t s, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send(s, w[i]);
  endtask

  task automatic chk_out(input string tag, input lu_sel_t ch, input logic [W-1:0] w);
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_chan"},  {14'd0, out_chan},  {14'd0, ch});
    chk({tag, "_word"},  {12'd0, out_word},  {12'd0, w});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = SEL_OR;
    in_bit    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_word",  {12'd0, out_word},  16'd0);
    chk("rst_out_chan",  {14'd0, out_chan},  16'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    end
    #2;
    rst_n = 1'b1;
    step();

    // Single word on XOR: bits 1,0,1,1 -> 4'b1101; nothing before the 4th bit
    send(SEL_XOR, 1'b1);
    chk("sw_idle1", {15'd0, out_valid}, 16'd0);
    send(SEL_XOR, 1'b0);
    chk("sw_idle2", {15'd0, out_valid}, 16'd0);
    send(SEL_XOR, 1'b1);
    chk("sw_idle3", {15'd0, out_valid}, 16'd0);
    send(SEL_XOR, 1'b1);
    chk("sw_not_yet", {15'd0, out_valid}, 16'd0);
    in_sel = SEL_XOR;
    #1;
    chk("sw_full_blocks", {15'd0, in_ready}, 16'd0);
    step();
    chk_out("sw", SEL_XOR, 4'b1101);
    step();
    chk("sw_one_cycle", {15'd0, out_valid}, 16'd0);

    // Backpressure: ch0 held in output register, ch1 full and blocked
    out_ready = 1'b0;
    send_word(SEL_OR, 4'b0000);
    send_word(SEL_NOR, 4'b1111);
    chk_out("bp_hold", SEL_OR, 4'b0000);
    in_valid = 1'b1;
    in_sel   = SEL_NOR;
    in_bit   = 1'b0;
    #1;
    chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
    step();
    step();
    chk_out("bp_stable", SEL_OR, 4'b0000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_out("bp_first", SEL_OR, 4'b0000);
    step();
    chk_out("bp_second", SEL_NOR, 4'b1111);
    step();
    chk("bp_drained", {15'd0, out_valid}, 16'd0);
    in_sel = SEL_NOR;
    #1;
    chk("bp_ready_back", {15'd0, in_ready}, 16'd1);

    // Round-robin: all four full, ch0 latched first
    out_ready = 1'b0;
    send_word(SEL_OR,   4'd1);
    send_word(SEL_NOR,  4'd2);
    send_word(SEL_XOR,  4'd3);
    send_word(SEL_XNOR, 4'd4);
    out_ready = 1'b1;
    #1;
    chk_out("rr1_a", SEL_OR, 4'd1);
    step();
    chk_out("rr1_b", SEL_NOR, 4'd2);
    step();
    chk_out("rr1_c", SEL_XOR, 4'd3);
    step();
    chk_out("rr1_d", SEL_XNOR, 4'd4);
    step();
    chk("rr1_done", {15'd0, out_valid}, 16'd0);

    out_ready = 1'b0;
    send_word(SEL_OR,   4'd5);
    send_word(SEL_NOR,  4'd6);
    send_word(SEL_XOR,  4'd7);
    send_word(SEL_XNOR, 4'd8);
    out_ready = 1'b1;
    #1;
    chk_out("rr2_a", SEL_OR, 4'd5);
    step();
    chk_out("rr2_b", SEL_NOR, 4'd6);
    step();
    chk_out("rr2_c", SEL_XOR, 4'd7);
    step();
    chk_out("rr2_d", SEL_XNOR, 4'd8);
    step();
    chk("rr2_done", {15'd0, out_valid}, 16'd0);

    // After a ch1 grant, ch3 must win over a refilled ch1
    out_ready = 1'b0;
    send_word(SEL_NOR,  4'h9);
    send_word(SEL_XNOR, 4'hA);
    send_word(SEL_NOR,  4'hB);
    out_ready = 1'b1;
    #1;
    chk_out("rr3_a", SEL_NOR, 4'h9);
    step();
    chk_out("rr3_b", SEL_XNOR, 4'hA);
    step();
    chk_out("rr3_c", SEL_NOR, 4'hB);
    step();
    chk("rr3_done", {15'd0, out_valid}, 16'd0);

    // Reset mid-word on ch3 discards the partial bits
    send(SEL_XNOR, 1'b1);
    send(SEL_XNOR, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_after_rst", {15'd0, out_valid}, 16'd0);
    send(SEL_XNOR, 1'b0);
    send(SEL_XNOR, 1'b0);
    send(SEL_XNOR, 1'b0);
    chk("mr_partial", {15'd0, out_valid}, 16'd0);
    send(SEL_XNOR, 1'b1);
    step();
    chk_out("mr_word", SEL_XNOR, 4'b1000);
    step();

    // Interleave ch0/ch3 per cycle
    send(SEL_OR,   1'b1);
    send(SEL_XNOR, 1'b0);
    send(SEL_OR,   1'b1);
    send(SEL_XNOR, 1'b1);
    send(SEL_OR,   1'b0);
    send(SEL_XNOR, 1'b0);
    send(SEL_OR,   1'b0);
    send(SEL_XNOR, 1'b1);
    chk_out("il_ch0", SEL_OR, 4'b0011);
    step();
    chk_out("il_ch3", SEL_XNOR, 4'b1010);
    step();
    chk("il_done", {15'd0, out_valid}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
